ram_cmd_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port synchronous RAM's command interface between two masters, e.g. the SPI slave front end and a local host port. Each requester issues RAM command words ({opcode[1:0], payload}); the arbiter grants one requester per transaction and keeps the address/data or address/read pair atomic. It routes the RAM's read data back to the owner and alternates priority round-robin between transactions. It sits directly in front of the RAM's din/rx_valid inputs and behind its dout/tx_valid outputs.

---
 rtl/ram_cmd_arbiter_if.sv | 44 ++++
 rtl/ram_cmd_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_ram_cmd_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_cmd_arbiter_if.sv
`default_nettype none
// ------------------------------------------------------------------
// ram_cmd_arbiter_if : requester and RAM command bundle for ram_cmd_arbiter
// Revision: 1.0
// ------------------------------------------------------------------
interface ram_cmd_arbiter_if #(
  parameter int ADDR_SIZE = 8
);
  logic                 req0_valid;
  logic [ADDR_SIZE+1:0] req0_din;
  logic                 req0_ready;
  logic [7:0]           req0_rd_data;
  logic                 req0_rd_valid;

  logic                 req1_valid;
  logic [ADDR_SIZE+1:0] req1_din;
  logic                 req1_ready;
  logic [7:0]           req1_rd_data;
  logic                 req1_rd_valid;

  logic [ADDR_SIZE+1:0] ram_din;
  logic                 ram_rx_valid;
  logic [7:0]           ram_dout;
  logic                 ram_tx_valid;

  logic                 owner;
  logic                 busy;
  logic                 err;

  modport slave (
    input  req0_valid, req0_din, req1_valid, req1_din, ram_dout, ram_tx_valid,
    output req0_ready, req0_rd_data, req0_rd_valid,
           req1_ready, req1_rd_data, req1_rd_valid,
           ram_din, ram_rx_valid, owner, busy, err
  );

  modport master (
    output req0_valid, req0_din, req1_valid, req1_din, ram_dout, ram_tx_valid,
    input  req0_ready, req0_rd_data, req0_rd_valid,
           req1_ready, req1_rd_data, req1_rd_valid,
           ram_din, ram_rx_valid, owner, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/ram_cmd_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// ram_cmd_arbiter : round-robin two-requester arbiter for a RAM command port
// Revision: 1.0
// ------------------------------------------------------------------
module ram_cmd_arbiter #(
  parameter int ADDR_SIZE    = 8,
  parameter int RD_TIMEOUT   = 4,
  parameter int HOLD_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  ram_cmd_arbiter_if.slave bus
);

  localparam int         c_W         = ADDR_SIZE + 2;
  localparam logic [7:0] c_HOLD_LAST = 8'(HOLD_TIMEOUT - 1);
  localparam logic [7:0] c_RD_LAST   = 8'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  state_t         r_state, w_state;
  logic           r_prio, w_prio;
  logic           r_owner, w_owner;
  logic           r_exp_rd, w_exp_rd;
  logic [7:0]     r_cnt, w_cnt;
  logic [c_W-1:0] r_din, w_din;
  logic           r_rxv, w_rxv;
  logic           r_err, w_err;
  logic           r_rdv0, w_rdv0, r_rdv1, w_rdv1;
  logic [7:0]     r_rdd0, w_rdd0, r_rdd1, w_rdd1;

  logic           w_win, w_sel, w_ready0, w_ready1, w_acc, w_start;
  logic [c_W-1:0] w_word;
  logic [1:0]     w_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_prio   <= 1'b0;
      r_owner  <= 1'b0;
      r_exp_rd <= 1'b0;
      r_cnt    <= 8'd0;
      r_din    <= '0;
      r_rxv    <= 1'b0;
      r_err    <= 1'b0;
      r_rdv0   <= 1'b0;
      r_rdv1   <= 1'b0;
      r_rdd0   <= 8'd0;
      r_rdd1   <= 8'd0;
    end else begin
      r_state  <= w_state;
      r_prio   <= w_prio;
      r_owner  <= w_owner;
      r_exp_rd <= w_exp_rd;
      r_cnt    <= w_cnt;
      r_din    <= w_din;
      r_rxv    <= w_rxv;
      r_err    <= w_err;
      r_rdv0   <= w_rdv0;
      r_rdv1   <= w_rdv1;
      r_rdd0   <= w_rdd0;
      r_rdd1   <= w_rdd1;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_prio   = r_prio;
    w_owner  = r_owner;
    w_exp_rd = r_exp_rd;
    w_cnt    = r_cnt;
    w_din    = r_din;
    w_rxv    = 1'b0;
    w_err    = 1'b0;
    w_rdv0   = 1'b0;
    w_rdv1   = 1'b0;
    w_rdd0   = r_rdd0;
    w_rdd1   = r_rdd1;
    w_ready0 = 1'b0;
    w_ready1 = 1'b0;

    // Lone requester wins outright; prio only breaks ties.
    w_win = r_prio;
    if (bus.req0_valid && !bus.req1_valid)
      w_win = 1'b0;
    else if (bus.req1_valid && !bus.req0_valid)
      w_win = 1'b1;

    case (r_state)
      IDLE: begin
        w_ready0 = bus.req0_valid && !w_win;
        w_ready1 = bus.req1_valid &&  w_win;
      end
      HOLD: begin
        w_ready0 = !r_owner;
        w_ready1 =  r_owner;
      end
      default: ;
    endcase

    w_sel   = (r_state == IDLE) ? w_win : r_owner;
    w_word  = w_sel ? bus.req1_din : bus.req0_din;
    w_acc   = w_sel ? (bus.req1_valid && w_ready1) : (bus.req0_valid && w_ready0);
    w_op    = w_word[c_W-1:c_W-2];
    w_start = !w_op[0];

    case (r_state)
      IDLE: begin
        if (w_acc) begin
          if (w_start) begin
            w_din    = w_word;
            w_rxv    = 1'b1;
            w_owner  = w_sel;
            w_exp_rd = w_op[1];
            w_cnt    = 8'd0;
            w_state  = HOLD;
          end else begin
            w_err = 1'b1;
          end
        end
      end

      HOLD: begin
        if (w_acc) begin
          w_cnt = 8'd0;
          if (w_start) begin
            w_din    = w_word;
            w_rxv    = 1'b1;
            w_exp_rd = w_op[1];
          end else if (w_op[1] == r_exp_rd) begin
            w_din = w_word;
            w_rxv = 1'b1;
            if (r_exp_rd) begin
              w_state = RD_WAIT;
            end else begin
              w_state = IDLE;
              w_prio  = !r_owner;
            end
          end else begin
            w_err = 1'b1;
          end
        end else if (r_cnt == c_HOLD_LAST) begin
          w_err   = 1'b1;
          w_state = IDLE;
          w_prio  = !r_owner;
          w_cnt   = 8'd0;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end

      RD_WAIT: begin
        if (bus.ram_tx_valid) begin
          if (r_owner) begin
            w_rdd1 = bus.ram_dout;
            w_rdv1 = 1'b1;
          end else begin
            w_rdd0 = bus.ram_dout;
            w_rdv0 = 1'b1;
          end
          w_state = IDLE;
          w_prio  = !r_owner;
          w_cnt   = 8'd0;
        end else if (r_cnt == c_RD_LAST) begin
          w_err   = 1'b1;
          w_state = IDLE;
          w_prio  = !r_owner;
          w_cnt   = 8'd0;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end

      default: begin
        w_state = IDLE;
        w_cnt   = 8'd0;
      end
    endcase
  end

  assign bus.req0_ready    = w_ready0;
  assign bus.req1_ready    = w_ready1;
  assign bus.req0_rd_data  = r_rdd0;
  assign bus.req0_rd_valid = r_rdv0;
  assign bus.req1_rd_data  = r_rdd1;
  assign bus.req1_rd_valid = r_rdv1;
  assign bus.ram_din       = r_din;
  assign bus.ram_rx_valid  = r_rxv;
  assign bus.owner         = r_owner;
  assign bus.busy          = (r_state != IDLE);
  assign bus.err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ram_cmd_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_ram_cmd_arbiter : directed scenarios plus random traffic vs a transaction model
// Revision: 1.0
// ------------------------------------------------------------------
module tb_ram_cmd_arbiter;
  localparam int AW      = 8;
  localparam int RD_TO   = 4;
  localparam int HOLD_TO = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ram_cmd_arbiter_if #(.ADDR_SIZE(AW)) bus ();

  ram_cmd_arbiter #(.ADDR_SIZE(AW), .RD_TIMEOUT(RD_TO), .HOLD_TIMEOUT(HOLD_TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] g, x;

  // Transaction-level model: who holds the port, what they owe, how long they idled
  bit         m_busy, m_wait, m_rd, m_owner, m_prio;
  int         m_idle;
  logic [9:0] e_din;
  bit         e_rxv, e_err, e_rdv0, e_rdv1;
  logic [7:0] e_rdd0, e_rdd1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit v0, input logic [9:0] d0, input bit v1, input logic [9:0] d1);
    bus.req0_valid = v0;
    bus.req0_din   = d0;
    bus.req1_valid = v1;
    bus.req1_din   = d1;
    #1;
  endtask

  function automatic logic [1:0] model_accept(input bit v0, input bit v1);
    if (!m_busy) return {v0 && (!v1 || !m_prio), v1 && (!v0 || m_prio)};
    if (m_wait)  return 2'b00;
    return {v0 && !m_owner, v1 && m_owner};
  endfunction

  task automatic model_release();
    m_busy = 0;
    m_wait = 0;
    m_prio = !m_owner;
    m_idle = 0;
  endtask

  task automatic model_edge(input bit v0, input logic [9:0] d0, input bit v1, input logic [9:0] d1,
                            input bit txv, input logic [7:0] dout);
    logic [1:0] a;
    logic [9:0] w;
    a = model_accept(v0, v1);
    w = a[0] ? d1 : d0;
    e_rxv = 0; e_err = 0; e_rdv0 = 0; e_rdv1 = 0;
    if (!m_busy) begin
      if (a != 2'b00) begin
        if (w[9:8] == 2'b00 || w[9:8] == 2'b10) begin
          e_din = w; e_rxv = 1; m_owner = a[0]; m_rd = w[9]; m_busy = 1; m_wait = 0; m_idle = 0;
        end else begin
          e_err = 1;
        end
      end
    end else if (m_wait) begin
      if (txv) begin
        if (m_owner) begin e_rdd1 = dout; e_rdv1 = 1; end
        else         begin e_rdd0 = dout; e_rdv0 = 1; end
        model_release();
      end else begin
        m_idle++;
        if (m_idle == RD_TO) begin e_err = 1; model_release(); end
      end
    end else if (a != 2'b00) begin
      m_idle = 0;
      if (w[9:8] == 2'b00 || w[9:8] == 2'b10) begin
        e_din = w; e_rxv = 1; m_rd = w[9];
      end else if (w[9:8] == (m_rd ? 2'b11 : 2'b01)) begin
        e_din = w; e_rxv = 1;
        if (m_rd) m_wait = 1;
        else      model_release();
      end else begin
        e_err = 1;
      end
    end else begin
      m_idle++;
      if (m_idle == HOLD_TO) begin e_err = 1; model_release(); end
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    set_req(0, '0, 0, '0);
    bus.ram_tx_valid = 0;
    bus.ram_dout     = '0;
    tick(); tick();
    g = 32'(bus.ram_din); x = 0; n_vec++;
    if (g !== x) begin n_bad++; $display("FAIL reset_din: got %h want %h", g, x); end
    g = {bus.ram_rx_valid, bus.req0_rd_valid, bus.req1_rd_valid}; x = 0; n_vec++;
    if (g !== x) begin n_bad++; $display("FAIL reset_strobes: got %h want %h", g, x); end
    g = {bus.req0_rd_data, bus.req1_rd_data}; x = 0; n_vec++;
    if (g !== x) begin n_bad++; $display("FAIL reset_rd_data: got %h want %h", g, x); end
    g = {bus.owner, bus.busy, bus.err}; x = 0; n_vec++;
    if (g !== x) begin n_bad++; $display("FAIL reset_status: got %h want %h", g, x); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_contention();
    for (int t = 0; t < 4; t++) begin
      bit         w;
      logic [9:0] s0, s1, t0, t1;
      w  = t[0];
      s0 = {2'b00, 8'(16 + t)};
      s1 = {2'b00, 8'(32 + t)};
      t0 = {2'b01, 8'(48 + t)};
      t1 = {2'b01, 8'(64 + t)};
      set_req(1, s0, 1, s1);
      g = {bus.req0_ready, bus.req1_ready}; x = w ? 2'b01 : 2'b10; n_vec++;
      if (g !== x) begin n_bad++; $display("FAIL cont_grant[%0d]: got %b want %b", t, g[1:0], x[1:0]); end
      tick();
      g = {bus.owner, bus.ram_rx_valid, bus.ram_din}; x = {w, 1'b1, w ? s1 : s0}; n_vec++;
      if (g !== x) begin n_bad++; $display("FAIL cont_start[%0d]: got %h want %h", t, g, x); end
      if (w) set_req(1, s0, 1, t1);
      else   set_req(1, t0, 1, s1);
      g = {bus.req0_ready, bus.req1_ready}; x = w ? 2'b01 : 2'b10; n_vec++;
      if (g !== x) begin n_bad++; $display("FAIL cont_hold[%0d]: got %b want %b", t, g[1:0], x[1:0]); end
      tick();
      g = {bus.busy, bus.ram_rx_valid, bus.ram_din}; x = {1'b0, 1'b1, w ? t1 : t0}; n_vec++;
      if (g !== x) begin n_bad++; $display("FAIL cont_term[%0d]: got %h want %h", t, g, x); end
    end
    set_req(0, '0, 0, '0);
  endtask

  task automatic test_single_write();
    set_req(1, 10'h0A0, 0, '0);
    g = 32'(bus.req0_ready); x = 1; n_vec++;
    if (g !== x) begin n_bad++; $display("FAIL wr_ready: got %h want %h", g, x); end
    tick();
    g = {bus.ram_rx_valid, bus.ram_din, bus.busy, bus.owner}; x = {1'b1, 10'h0A0, 1'b1, 1'b0}; n_vec++;
    if (g !== x) begin n_bad++; $display("FAIL wr_addr: got %h want %h", g, x); end
    set_req(1, 10'h155, 0, '0);
    tick();
    g = {bus.ram_rx_valid, bus.ram_din, bus.busy}; x = {1'b1, 10'h155, 1'b0}; n_vec++;
    if (g !== x) begin n_bad++; $display("FAIL wr_data: got %h want %h", g, x); end
    set_req(1, 10'h0B0, 1, 10'h0C0);
    g = {bus.req0_ready, bus.req1_ready}; x = 2'b01; n_vec++;
    if (g !== x) begin n_bad++; $display("FAIL wr_prio: got %b want %b", g[1:0], x[1:0]); end
    set_req(0, '0, 0, '0);
    tick();
    g = 32'(bus.ram_rx_valid); x = 0; n_vec++;
    if (g !== x) begin n_bad++; $display("FAIL wr_quiet: got %h want %h", g, x); end
  endtask

  task automatic test_read();
    set_req(0, '0, 1, 10'h2A0);
    tick();
    g = {bus.ram_rx_valid, bus.ram_din, bus.owner}; x = {1'b1, 10'h2A0, 1'b1}; n_vec++;
    if (g !== x) begin n_bad++; $display("FAIL rd_addr: got %h want %h", g, x); end
    set_req(0, '0, 1, 10'h3A0);
    tick();
    g = {bus.ram_rx_valid, bus.ram_din, bus.busy}; x = {1'b1, 10'h3A0, 1'b1}; n_vec++;
    if (g !== x) begin n_bad++; $display("FAIL rd_term: got %h want %h", g, x); end
    set_req(1, 10'h0A0, 1, 10'h2B0);
    g = {bus.req0_ready, bus.req1_ready}; x = 2'b00; n_vec++;
    if (g !== x) begin n_bad++; $display("FAIL rd_wait_ready: got %b want %b", g[1:0], x[1:0]); end
    tick();
    g = {bus.ram_rx_valid, bus.busy}; x = 2'b01; n_vec++;
    if (g !== x) begin n_bad++; $display("FAIL rd_wait: got %b want %b", g[1:0], x[1:0]); end
    set_req(0, '0, 0, '0);
    bus.ram_tx_valid = 1;
    bus.ram_dout     = 8'h55;
    tick();
    g = {bus.req1_rd_valid, bus.req1_rd_data, bus.req0_rd_valid, bus.busy}; x = {1'b1, 8'h55, 1'b0, 1'b0}; n_vec++;
    if (g !== x) begin n_bad++; $display("FAIL rd_return: got %h want %h", g, x); end
    bus.ram_tx_valid = 0;
    tick();
    g = {bus.req1_rd_valid, bus.req1_rd_data}; x = {1'b0, 8'h55}; n_vec++;
    if (g !== x) begin n_bad++; $display("FAIL rd_pulse: got %h want %h", g, x); end
  endtask

  task automatic test_protocol_errors();
    set_req(1, 10'h155, 0, '0);
    tick();
    g = {bus.ram_rx_valid, bus.err, bus.busy}; x = 3'b010; n_vec++;
    if (g !== x) begin n_bad++; $display("FAIL err_idle: got %b want %b", g[2:0], x[2:0]); end
    set_req(1, 10'h0A0, 1, 10'h011);
    g = {bus.req0_ready, bus.req1_ready}; x = 2'b10; n_vec++;
    if (g !== x) begin n_bad++; $display("FAIL err_prio_kept: got %b want %b", g[1:0], x[1:0]); end
    set_req(1, 10'h0A0, 0, '0);
    tick();
    g = {bus.ram_rx_valid, bus.err, bus.busy, bus.ram_din}; x = {3'b101, 10'h0A0}; n_vec++;
    if (g !== x) begin n_bad++; $display("FAIL err_grant: got %h want %h", g, x); end
    set_req(1, 10'h3AA, 0, '0);
    tick();
    g = {bus.ram_rx_valid, bus.err, bus.busy}; x = 3'b011; n_vec++;
    if (g !== x) begin n_bad++; $display("FAIL err_hold: got %b want %b", g[2:0], x[2:0]); end
    set_req(1, 10'h155, 0, '0);
    tick();
    g = {bus.ram_rx_valid, bus.ram_din, bus.busy, bus.err}; x = {1'b1, 10'h155, 2'b00}; n_vec++;
    if (g !== x) begin n_bad++; $display("FAIL err_recover: got %h want %h", g, x); end
    set_req(0, '0, 0, '0);
  endtask

  task automatic test_hold_timeout();
    set_req(0, '0, 1, 10'h011);
    tick();
    set_req(0, '0, 0, '0);
    for (int i = 1; i < HOLD_TO; i++) begin
      tick();
      g = {bus.busy, bus.err}; x = 2'b10; n_vec++;
      if (g !== x) begin n_bad++; $display("FAIL to_hold_wait[%0d]: got %b want %b", i, g[1:0], x[1:0]); end
    end
    tick();
    g = {bus.busy, bus.err}; x = 2'b01; n_vec++;
    if (g !== x) begin n_bad++; $display("FAIL to_hold_fire: got %b want %b", g[1:0], x[1:0]); end
    tick();
    g = 32'(bus.err); x = 0; n_vec++;
    if (g !== x) begin n_bad++; $display("FAIL to_hold_pulse: got %h want %h", g, x); end
    set_req(1, 10'h0A0, 1, 10'h0B0);
    g = {bus.req0_ready, bus.req1_ready}; x = 2'b10; n_vec++;
    if (g !== x) begin n_bad++; $display("FAIL to_hold_prio: got %b want %b", g[1:0], x[1:0]); end
    set_req(0, '0, 0, '0);
  endtask

  task automatic test_rd_timeout();
    set_req(1, 10'h200, 0, '0);
    tick();
    set_req(1, 10'h300, 0, '0);
    tick();
    set_req(0, '0, 0, '0);
    for (int i = 1; i < RD_TO; i++) begin
      tick();
      g = {bus.busy, bus.err}; x = 2'b10; n_vec++;
      if (g !== x) begin n_bad++; $display("FAIL rdto_wait[%0d]: got %b want %b", i, g[1:0], x[1:0]); end
    end
    tick();
    g = {bus.busy, bus.err, bus.req0_rd_valid}; x = 3'b010; n_vec++;
    if (g !== x) begin n_bad++; $display("FAIL rdto_fire: got %b want %b", g[2:0], x[2:0]); end
    bus.ram_tx_valid = 1;
    bus.ram_dout     = 8'h77;
    tick();
    g = {bus.req0_rd_valid, bus.req1_rd_valid, bus.req0_rd_data}; x = 0; n_vec++;
    if (g !== x) begin n_bad++; $display("FAIL rdto_late_tx: got %h want %h", g, x); end
    bus.ram_tx_valid = 0;
  endtask

  task automatic test_reset_mid_read();
    set_req(0, '0, 1, 10'h2C0);
    tick();
    set_req(0, '0, 1, 10'h3C0);
    tick();
    g = {bus.ram_rx_valid, bus.busy}; x = 2'b11; n_vec++;
    if (g !== x) begin n_bad++; $display("FAIL rst_pre: got %b want %b", g[1:0], x[1:0]); end
    rst_n = 0;
    #1;
    g = {bus.ram_din, bus.ram_rx_valid, bus.req0_rd_data, bus.req0_rd_valid,
         bus.req1_rd_data, bus.req1_rd_valid, bus.owner, bus.busy, bus.err};
    x = 0; n_vec++;
    if (g !== x) begin n_bad++; $display("FAIL rst_async: got %h want %h", g, x); end
    set_req(0, '0, 0, '0);
    tick();
    rst_n = 1;
    set_req(1, 10'h0E0, 1, 10'h0D0);
    g = {bus.req0_ready, bus.req1_ready}; x = 2'b10; n_vec++;
    if (g !== x) begin n_bad++; $display("FAIL rst_prio: got %b want %b", g[1:0], x[1:0]); end
    set_req(0, '0, 1, 10'h0D0);
    g = 32'(bus.req1_ready); x = 1; n_vec++;
    if (g !== x) begin n_bad++; $display("FAIL rst_regrant: got %h want %h", g, x); end
    tick();
    g = {bus.owner, bus.busy, bus.ram_rx_valid, bus.ram_din}; x = {3'b111, 10'h0D0}; n_vec++;
    if (g !== x) begin n_bad++; $display("FAIL rst_owner: got %h want %h", g, x); end
    set_req(0, '0, 1, 10'h1D0);
    tick();
    set_req(0, '0, 0, '0);
  endtask

  task automatic test_random();
    rst_n = 0;
    set_req(0, '0, 0, '0);
    bus.ram_tx_valid = 0;
    tick();
    rst_n = 1;
    m_busy = 0; m_wait = 0; m_rd = 0; m_owner = 0; m_prio = 0; m_idle = 0;
    e_din = '0; e_rdd0 = '0; e_rdd1 = '0;
    for (int c = 0; c < 600; c++) begin
      bit         v0, v1, txv;
      logic [9:0] d0, d1;
      logic [7:0] dout;
      v0   = 1'($urandom_range(0, 1));
      v1   = 1'($urandom_range(0, 1));
      d0   = 10'($urandom);
      d1   = 10'($urandom);
      txv  = ($urandom_range(0, 2) == 0);
      dout = 8'($urandom);
      set_req(v0, d0, v1, d1);
      bus.ram_tx_valid = txv;
      bus.ram_dout     = dout;
      #1;
      g = {v0 && bus.req0_ready, v1 && bus.req1_ready}; x = model_accept(v0, v1); n_vec++;
      if (g !== x) begin n_bad++; $display("FAIL rnd_accept@%0d: got %b want %b", c, g[1:0], x[1:0]); end
      model_edge(v0, d0, v1, d1, txv, dout);
      tick();
      g = {bus.ram_rx_valid, bus.err, bus.req0_rd_valid, bus.req1_rd_valid, bus.busy};
      x = {e_rxv, e_err, e_rdv0, e_rdv1, m_busy}; n_vec++;
      if (g !== x) begin n_bad++; $display("FAIL rnd_ctrl@%0d: got %b want %b", c, g[4:0], x[4:0]); end
      g = {bus.req0_rd_data, bus.req1_rd_data}; x = {e_rdd0, e_rdd1}; n_vec++;
      if (g !== x) begin n_bad++; $display("FAIL rnd_rdata@%0d: got %h want %h", c, g, x); end
      if (e_rxv) begin
        g = 32'(bus.ram_din); x = 32'(e_din); n_vec++;
        if (g !== x) begin n_bad++; $display("FAIL rnd_din@%0d: got %h want %h", c, g, x); end
      end
      if (m_busy) begin
        g = 32'(bus.owner); x = 32'(m_owner); n_vec++;
        if (g !== x) begin n_bad++; $display("FAIL rnd_owner@%0d: got %h want %h", c, g, x); end
      end
    end
    set_req(0, '0, 0, '0);
    bus.ram_tx_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_contention();
    test_single_write();
    test_read();
    test_protocol_errors();
    test_hold_timeout();
    test_rd_timeout();
    test_reset_mid_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
